core_power_seq: RTL
===================

# core_power_seq

Core power sequencer that drives the per-core and global clock-enable inputs of the clock generator and waits for each core's synchronised reset release before reporting completion. It accepts one enable/disable request at a time over a valid/ready handshake and staggers successive transitions to limit clock-turn-on inrush. It sits between the system control register block and the clock generator. It is the initiator that owns `global_enable` and `core_enable`, and it consumes `core_rst_n`.

## Interface
- `NUM_CORES`, 4, number of cores sequenced
- `STAGGER_CYCLES`, 8, idle gap after a completed transition, and settle time for a disable (≥1)
- `ACK_TIMEOUT`, 64, maximum cycles to wait for reset release after an enable (≥1)

Ports:
- `clk_in` input 1: single clock; all logic on its rising edge
- `rst_n_in` input 1: synchronous, active-low reset
- `req_valid` input 1: request present
- `req_ready` output 1: sequencer can accept a request
- `req_core` input `$clog2(NUM_CORES)` (min 1): target core index
- `req_on` input 1: 1 = enable core, 0 = disable core
- `core_rst_n` input NUM_CORES: per-core reset release from the clock generator; synchronised internally
- `global_enable` output 1: global clock enable to the clock generator
- `core_enable` output NUM_CORES: per-core clock enables
- `done_valid` output 1: one-cycle completion pulse
- `done_error` output 1: qualifies `done_valid`; 1 = timeout or bad index
- `cores_ready` output NUM_CORES: `core_enable & core_rst_n_sync`

## Operation
- `core_rst_n` passes through a 2-flop synchroniser per bit. The decision logic uses only the second stage (`core_rst_n_sync`).
- The state machine has five states: IDLE, EN_WAIT, DIS_SETTLE, DONE, GAP. `req_ready` = (state == IDLE).
- Accept means `req_valid && req_ready` on an edge. At accept, `req_core`, `req_on` and a bad-index flag (`req_core >= NUM_CORES`) are latched.
- **Bad index:** go to DONE with error. No output changes. No GAP afterwards.
- **Redundant request** (enable an already-enabled core, or disable a disabled core): go to DONE without error. No GAP afterwards.
- **Enable:**
  - Set `core_enable[i]` and `global_enable`, then go to EN_WAIT with the counter cleared.
  - If `core_rst_n_sync[i]` is 1, go to DONE with no error.
  - Otherwise, if the counter equals `ACK_TIMEOUT-1`, go to DONE with error and clear `core_enable[i]`.
  - Otherwise increment the counter.
- **Disable:**
  - Clear `core_enable[i]` and go to DIS_SETTLE.
  - After `STAGGER_CYCLES` cycles, go to DONE.
  - On entry to DONE, clear `global_enable` if `core_enable` is all zero.
- A timeout error also clears `global_enable` if no other core remains enabled.
- **DONE:** `done_valid` = 1 for exactly one cycle. Next state is GAP for real enable/disable transitions (including timeout), or IDLE for redundant or bad-index requests.
- **GAP:** holds for `STAGGER_CYCLES` cycles, then goes to IDLE.
- A reset sync value that is already high (core previously enabled since the last `rst_n_in`) counts as an immediate acknowledge.
- The counter is sized `$clog2(max(STAGGER_CYCLES, ACK_TIMEOUT)+1)` and never wraps.

## Timing
- **Reset:** while `rst_n_in` = 0 at an edge, every output is 0 (`req_ready`, `global_enable`, `core_enable`, `done_valid`, `done_error`, `cores_ready`). The state returns to IDLE, the counter and synchronisers clear, and no done pulse is produced.
- `req_ready` = 1 in the first cycle after reset release.
- Reset asserted mid-operation aborts the request. Enables drop at the next edge.
- With accept at edge T:
  - `core_enable[i]` changes at T+1.
  - `req_ready` is low from T+1 until GAP ends.
- **Enable completion:** `done_valid` rises 3 cycles after `core_rst_n[i]` rises (2 sync stages + 1 decision cycle), provided the rise happens inside EN_WAIT.
  - Already-high case: `done_valid` at T+2.
  - Timeout: `done_valid` at T+1+`ACK_TIMEOUT`.
- **Disable completion:** `done_valid` at T+1+`STAGGER_CYCLES`.
- **Redundant or bad-index request:** `done_valid` at T+1. `req_ready` at T+2.
- **Real transition:** `req_ready` returns `STAGGER_CYCLES`+1 cycles after `done_valid`.
- `done_error` is valid only while `done_valid` = 1; otherwise it is 0.
- `cores_ready` is registered logic on `core_enable` and the sync outputs; there is no combinational path from `core_rst_n`.

## Test plan
1. **Reset:** hold `rst_n_in`=0 for 5 cycles with `req_valid`=1 → all outputs 0. After release, `req_ready`=1 at the first cycle and no request has been accepted during reset.
2. **Enable core 1 from reset:** bench raises `core_rst_n[1]` 5 cycles after `core_enable[1]` rises → `global_enable`=1 and `core_enable`=4'b0010 at T+1; `done_valid`=1, `done_error`=0 at T+9; `cores_ready`=4'b0010; `req_ready` again at T+18.
3. **Timeout:** enable core 2 with `core_rst_n[2]` held 0 → `done_valid`=1, `done_error`=1 at T+65; `core_enable[2]`=0; `global_enable`=0 if no other core is on.
4. **Disable last core:** with only core 0 enabled, disable core 0 → `core_enable`=0 at T+1; `done_valid` at T+9; `global_enable`=0 in that same cycle.
5. **Redundant and bad index:** enable an already-enabled core → `done_valid` at T+1 with error 0, `req_ready` at T+2. Then, with `NUM_CORES`=3 and `req_core`=3 → `done_error`=1 and `core_enable` unchanged.
6. **Reset mid-operation:** assert `rst_n_in`=0 during EN_WAIT for core 3 → `core_enable`=0 and `global_enable`=0 at the next edge, and no `done_valid` is produced.

Source files
------------

// File: rtl/core_power_seq_if.sv
// rtl/core_power_seq_if.sv - request/response and clock-enable bundle for core_power_seq
//
// Purpose: groups the request handshake, completion pulse, per-core clock
//          enables and per-core reset-release inputs of the core power sequencer.
// Signals:
//   req_valid/req_ready  request handshake (requester -> sequencer)
//   req_core, req_on     target core index and direction (1 = enable)
//   core_rst_n           per-core reset release from the clock generator
//   global_enable        global clock enable to the clock generator
//   core_enable          per-core clock enables
//   done_valid           one-cycle completion pulse, done_error qualifies it
//   cores_ready          cores that are enabled and out of reset
// Modports: master = requester/clock-generator side, slave = sequencer.
interface core_power_seq_if #(
  parameter int NUM_CORES = 4
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                 req_valid;
  logic                 req_ready;
  logic [IDX_W-1:0]     req_core;
  logic                 req_on;
  logic [NUM_CORES-1:0] core_rst_n;
  logic                 global_enable;
  logic [NUM_CORES-1:0] core_enable;
  logic                 done_valid;
  logic                 done_error;
  logic [NUM_CORES-1:0] cores_ready;

  modport master (
    output req_valid, req_core, req_on, core_rst_n,
    input  req_ready, global_enable, core_enable, done_valid, done_error, cores_ready
  );

  modport slave (
    input  req_valid, req_core, req_on, core_rst_n,
    output req_ready, global_enable, core_enable, done_valid, done_error, cores_ready
  );
endinterface

// File: rtl/core_power_seq.sv
// rtl/core_power_seq.sv - staggered per-core clock-enable sequencer
//
// Purpose: accepts one enable/disable request at a time, drives the per-core
//          and global clock enables, waits for the synchronised reset release
//          of an enabled core (with timeout), lets a disabled core settle, and
//          enforces an idle gap after every real transition to limit inrush.
// Ports:
//   clk_in    single clock, rising edge
//   rst_n_in  synchronous active-low reset
//   bus       core_power_seq_if.slave (request handshake, enables, done pulse,
//             core_rst_n inputs, cores_ready)
module core_power_seq #(
  parameter int NUM_CORES      = 4,
  parameter int STAGGER_CYCLES = 8,
  parameter int ACK_TIMEOUT    = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  core_power_seq_if.slave        bus
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int MAXV  = (STAGGER_CYCLES > ACK_TIMEOUT) ? STAGGER_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W = $clog2(MAXV + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN_WAIT,
    S_DIS_SETTLE,
    S_DONE,
    S_GAP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_CORES-1:0] r_sync1;
  logic [NUM_CORES-1:0] r_sync2;
  logic [NUM_CORES-1:0] r_core_bit;
  logic                 r_real;
  logic                 r_req_ready;
  logic                 r_global_enable;
  logic [NUM_CORES-1:0] r_core_enable;
  logic                 r_done_valid;
  logic                 r_done_error;
  logic [NUM_CORES-1:0] r_cores_ready;

  logic [NUM_CORES-1:0] w_req_bit;
  logic                 w_req_bad;
  logic                 w_req_redundant;
  logic [NUM_CORES-1:0] w_en_drop;

  // One-hot of the requested core; all zero for an out-of-range index.
  always_comb begin
    w_req_bit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (bus.req_core == i[IDX_W-1:0]) begin
        w_req_bit[i] = 1'b1;
      end
    end
  end

  assign w_req_bad       = int'(bus.req_core) >= NUM_CORES;
  assign w_req_redundant = bus.req_on ? (|(r_core_enable & w_req_bit))
                                      : ~(|(r_core_enable & w_req_bit));
  assign w_en_drop       = r_core_enable & ~r_core_bit;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_sync1         <= '0;
      r_sync2         <= '0;
      r_core_bit      <= '0;
      r_real          <= 1'b0;
      r_req_ready     <= 1'b0;
      r_global_enable <= 1'b0;
      r_core_enable   <= '0;
      r_done_valid    <= 1'b0;
      r_done_error    <= 1'b0;
      r_cores_ready   <= '0;
    end else begin
      r_sync1       <= bus.core_rst_n;
      r_sync2       <= r_sync1;
      r_cores_ready <= r_core_enable & r_sync2;
      r_done_valid  <= 1'b0;
      r_done_error  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // ready is registered, so the first cycle after reset never accepts
          r_req_ready <= 1'b1;
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_core_bit  <= w_req_bit;
            r_cnt       <= '0;
            if (w_req_bad || w_req_redundant) begin
              r_state      <= S_DONE;
              r_real       <= 1'b0;
              r_done_valid <= 1'b1;
              r_done_error <= w_req_bad;
            end else if (bus.req_on) begin
              r_state         <= S_EN_WAIT;
              r_real          <= 1'b1;
              r_core_enable   <= r_core_enable | w_req_bit;
              r_global_enable <= 1'b1;
            end else begin
              r_state       <= S_DIS_SETTLE;
              r_real        <= 1'b1;
              r_core_enable <= r_core_enable & ~w_req_bit;
            end
          end
        end

        S_EN_WAIT: begin
          // acknowledge wins over timeout on the final cycle
          if (|(r_sync2 & r_core_bit)) begin
            r_state      <= S_DONE;
            r_done_valid <= 1'b1;
          end else if (r_cnt == ACK_LAST) begin
            r_state         <= S_DONE;
            r_done_valid    <= 1'b1;
            r_done_error    <= 1'b1;
            r_core_enable   <= w_en_drop;
            r_global_enable <= |w_en_drop;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DIS_SETTLE: begin
          if (r_cnt == STG_LAST) begin
            r_state         <= S_DONE;
            r_done_valid    <= 1'b1;
            r_global_enable <= |r_core_enable;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_cnt <= '0;
          if (r_real) begin
            r_state <= S_GAP;
          end else begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end

        S_GAP: begin
          if (r_cnt == STG_LAST) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.global_enable = r_global_enable;
  assign bus.core_enable   = r_core_enable;
  assign bus.done_valid    = r_done_valid;
  assign bus.done_error    = r_done_error;
  assign bus.cores_ready   = r_cores_ready;
endmodule
